// File: rtl/pipe_trace.sv
// pipe_trace -- instruction-trace tracker for the 5-stage MIPS pipeline.
//
// Shadows the datapath pipeline registers so that the instruction word and
// valid bit held in each stage (D, E, M, W) are visible in one place. It
// applies the same stall/flush controls as the hazard unit. It also counts
// cycles spent tracking and retired instructions, and it detects the
// program-terminating instruction.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   start                        leave IDLE and begin tracking
//   instrF, validF               fetched word and its valid flag
//   stallD, flushD, flushE       hazard-unit controls
//   instrF_o                     combinational copy of instrF
//   instrD/E/M/W, validD/E/M/W   per-stage word and valid flag
//   trace_en                     high while tracking (RUN)
//   cycles, retired              saturating RUN-cycle and retire counters
//   halted                       sticky, HALT_INSTR has retired
module pipe_trace #(
  parameter logic [31:0] NOP        = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'h0000_000c,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      instrF,
  input  logic             validF,
  input  logic             stallD,
  input  logic             flushD,
  input  logic             flushE,
  output logic [31:0]      instrF_o,
  output logic [31:0]      instrD,
  output logic [31:0]      instrE,
  output logic [31:0]      instrM,
  output logic [31:0]      instrW,
  output logic             validD,
  output logic             validE,
  output logic             validM,
  output logic             validW,
  output logic             trace_en,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] retired,
  output logic             halted
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t state, state_nxt;

  // p0 = D, p1 = E, p2 = M, p3 = W
  logic [31:0]      instr_p0, instr_p1, instr_p2, instr_p3;
  logic             vld_p0, vld_p1, vld_p2, vld_p3;
  logic [CNT_W-1:0] cycles_q, retired_q;
  logic             adv;
  logic             halt_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign adv      = (state == RUN);
  assign halt_hit = vld_p3 && (instr_p3 == HALT_INSTR);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (halt_hit) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  // F -> D: stall beats flush
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_p0 <= NOP;
      vld_p0   <= 1'b0;
    end else if (adv && !stallD) begin
      instr_p0 <= flushD ? NOP  : instrF;
      vld_p0   <= flushD ? 1'b0 : validF;
    end
  end

  // D -> E: never stalled, flush inserts a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_p1 <= NOP;
      vld_p1   <= 1'b0;
    end else if (adv) begin
      instr_p1 <= flushE ? NOP  : instr_p0;
      vld_p1   <= flushE ? 1'b0 : vld_p0;
    end
  end

  // E -> M -> W: unconditional advance
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_p2 <= NOP;
      vld_p2   <= 1'b0;
      instr_p3 <= NOP;
      vld_p3   <= 1'b0;
    end else if (adv) begin
      instr_p2 <= instr_p1;
      vld_p2   <= vld_p1;
      instr_p3 <= instr_p2;
      vld_p3   <= vld_p2;
    end
  end

  // Counters: the halting edge still counts as a RUN edge
  always_ff @(posedge clk) begin
    if (reset) begin
      cycles_q  <= '0;
      retired_q <= '0;
    end else if (adv) begin
      cycles_q <= sat_inc(cycles_q);
      if (vld_p3) retired_q <= sat_inc(retired_q);
    end
  end

  assign instrF_o = instrF;
  assign instrD   = instr_p0;
  assign instrE   = instr_p1;
  assign instrM   = instr_p2;
  assign instrW   = instr_p3;
  assign validD   = vld_p0;
  assign validE   = vld_p1;
  assign validM   = vld_p2;
  assign validW   = vld_p3;
  assign cycles   = cycles_q;
  assign retired  = retired_q;
  assign trace_en = (state == RUN);
  assign halted   = (state == HALTED);

endmodule

// File: tb/tb_pipe_trace.sv
// Bench for pipe_trace: scenario tasks with random stimulus checked against
// a stage-array reference model. A second instance with 4-bit counters
// covers saturation.
module tb_pipe_trace;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] HALT = 32'h0000_000c;
  localparam logic [31:0] LW   = 32'h8c22_0000;

  logic        clk = 1'b0;
  logic        reset, start, validF, stallD, flushD, flushE;
  logic [31:0] instrF;

  logic [31:0] instrF_o, instrD, instrE, instrM, instrW;
  logic        validD, validE, validM, validW, trace_en, halted;
  logic [31:0] cycles, retired;

  logic [31:0] q_instrF_o, q_instrD, q_instrE, q_instrM, q_instrW;
  logic        q_validD, q_validE, q_validM, q_validW, q_trace_en, q_halted;
  logic [3:0]  q_cycles, q_retired;

  logic [31:0] d_ins[4];
  logic        d_v[4];
  assign d_ins[0] = instrD; assign d_ins[1] = instrE;
  assign d_ins[2] = instrM; assign d_ins[3] = instrW;
  assign d_v[0] = validD; assign d_v[1] = validE;
  assign d_v[2] = validM; assign d_v[3] = validW;

  pipe_trace dut (
    .clk(clk), .reset(reset), .start(start), .instrF(instrF), .validF(validF),
    .stallD(stallD), .flushD(flushD), .flushE(flushE), .instrF_o(instrF_o),
    .instrD(instrD), .instrE(instrE), .instrM(instrM), .instrW(instrW),
    .validD(validD), .validE(validE), .validM(validM), .validW(validW),
    .trace_en(trace_en), .cycles(cycles), .retired(retired), .halted(halted)
  );

  pipe_trace #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .instrF(instrF), .validF(validF),
    .stallD(stallD), .flushD(flushD), .flushE(flushE), .instrF_o(q_instrF_o),
    .instrD(q_instrD), .instrE(q_instrE), .instrM(q_instrM), .instrW(q_instrW),
    .validD(q_validD), .validE(q_validE), .validM(q_validM), .validW(q_validW),
    .trace_en(q_trace_en), .cycles(q_cycles), .retired(q_retired), .halted(q_halted)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  // Reference model: mode 0 = idle, 1 = tracking, 2 = halted
  logic [31:0] m_ins[4];
  logic        m_v[4];
  int          m_mode;
  longint      m_cyc, m_ret;
  int          m_cyc4, m_ret4;
  localparam longint MAX32 = 64'd4294967295;

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = w ^ 32'h1000_0000;
    return w;
  endfunction

  task automatic step(input logic [31:0] f, input logic vf, input logic sd,
                      input logic fd, input logic fe, input logic st,
                      input logic rs);
    logic halt_now;
    instrF = f; validF = vf; stallD = sd; flushD = fd; flushE = fe;
    start = st; reset = rs;
    @(posedge clk);
    if (rs) begin
      for (int i = 0; i < 4; i++) begin m_ins[i] = NOP; m_v[i] = 1'b0; end
      m_mode = 0; m_cyc = 0; m_ret = 0; m_cyc4 = 0; m_ret4 = 0;
    end else if (m_mode == 0) begin
      if (st) m_mode = 1;
    end else if (m_mode == 1) begin
      halt_now = m_v[3] && (m_ins[3] == HALT);
      m_cyc  = (m_cyc + 1 > MAX32) ? MAX32 : m_cyc + 1;
      m_cyc4 = (m_cyc4 + 1 > 15) ? 15 : m_cyc4 + 1;
      if (m_v[3]) begin
        m_ret  = (m_ret + 1 > MAX32) ? MAX32 : m_ret + 1;
        m_ret4 = (m_ret4 + 1 > 15) ? 15 : m_ret4 + 1;
      end
      m_ins[3] = m_ins[2]; m_v[3] = m_v[2];
      m_ins[2] = m_ins[1]; m_v[2] = m_v[1];
      m_ins[1] = fe ? NOP : m_ins[0]; m_v[1] = fe ? 1'b0 : m_v[0];
      if (!sd) begin
        m_ins[0] = fd ? NOP : f; m_v[0] = fd ? 1'b0 : vf;
      end
      if (halt_now) m_mode = 2;
    end
    #1;
  endtask

  task automatic go(input logic [31:0] f, input logic vf);
    step(f, vf, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic restart();
    step(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    step(32'hdead_beef, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      n_run++;
      if (d_ins[i] !== NOP || d_v[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_stage%0d got=%h/%b want=%h/0", i, d_ins[i], d_v[i], NOP);
      end
    end
    n_run++;
    if (cycles !== 32'd0 || retired !== 32'd0 || halted !== 1'b0 || trace_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got cyc=%0d ret=%0d halt=%b ten=%b want 0/0/0/0",
               cycles, retired, halted, trace_en);
    end
  endtask

  task automatic test_idle_hold();
    for (int c = 0; c < 5; c++) begin
      go(rand_word(), 1'($urandom));
      n_run++;
      if (instrF_o !== instrF) begin
        n_fail++; $display("FAIL idle_passthru got=%h want=%h", instrF_o, instrF);
      end
      n_run++;
      if (instrD !== NOP || instrE !== NOP || instrM !== NOP || instrW !== NOP ||
          validD !== 1'b0 || cycles !== 32'd0 || trace_en !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold got D=%h E=%h M=%h W=%h vD=%b cyc=%0d ten=%b want NOP/0",
                 instrD, instrE, instrM, instrW, validD, cycles, trace_en);
      end
    end
  endtask

  task automatic test_straight();
    logic [31:0] prog[4];
    logic [31:0] snap_w, snap_c, snap_r;
    prog[0] = 32'h2001_0001; prog[1] = 32'h2002_0002;
    prog[2] = 32'h0022_1820; prog[3] = HALT;
    restart();
    n_run++;
    if (trace_en !== 1'b1 || cycles !== 32'd0) begin
      n_fail++; $display("FAIL start_ten got ten=%b cyc=%0d want 1/0", trace_en, cycles);
    end
    for (int i = 0; i < 4; i++) go(prog[i], 1'b1);
    for (int i = 0; i < 4; i++) begin
      n_run++;
      if (instrW !== prog[i] || validW !== 1'b1 || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL straight_W%0d got=%h v=%b h=%b want=%h v=1 h=0",
                 i, instrW, validW, halted, prog[i]);
      end
      go(NOP, 1'b0);
    end
    n_run++;
    if (halted !== 1'b1 || retired !== 32'd4 || trace_en !== 1'b0 || cycles !== 32'(m_cyc)) begin
      n_fail++;
      $display("FAIL straight_halt got h=%b ret=%0d ten=%b cyc=%0d want 1/4/0/%0d",
               halted, retired, trace_en, cycles, m_cyc);
    end
    snap_w = instrW; snap_c = cycles; snap_r = retired;
    for (int c = 0; c < 10; c++) begin
      step(rand_word(), 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
      n_run++;
      if (instrW !== snap_w || cycles !== snap_c || retired !== snap_r ||
          halted !== 1'b1 || trace_en !== 1'b0 || instrD !== m_ins[0]) begin
        n_fail++;
        $display("FAIL halt_frozen got W=%h cyc=%0d ret=%0d h=%b D=%h want W=%h cyc=%0d ret=%0d h=1 D=%h",
                 instrW, cycles, retired, halted, instrD, snap_w, snap_c, snap_r, m_ins[0]);
      end
    end
  endtask

  task automatic test_load_use();
    logic [31:0] rr;
    restart();
    for (int i = 0; i < 3; i++) go(rand_word(), 1'b1);
    go(LW, 1'b1);
    step(rand_word(), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_run++;
    if (instrD !== LW || validD !== 1'b1 || instrE !== NOP || validE !== 1'b0) begin
      n_fail++;
      $display("FAIL loaduse_stall got D=%h vD=%b E=%h vE=%b want D=%h vD=1 E=NOP vE=0",
               instrD, validD, instrE, validE, LW);
    end
    go(rand_word(), 1'b1);
    go(rand_word(), 1'b1);
    n_run++;
    if (instrW !== NOP || validW !== 1'b0) begin
      n_fail++; $display("FAIL loaduse_bubbleW got=%h v=%b want NOP v=0", instrW, validW);
    end
    rr = retired;
    go(rand_word(), 1'b1);
    n_run++;
    if (retired !== rr || instrW !== LW) begin
      n_fail++;
      $display("FAIL loaduse_retire got ret=%0d W=%h want ret=%0d W=%h", retired, instrW, rr, LW);
    end
  endtask

  task automatic test_branch();
    logic [31:0] c;
    restart();
    go(rand_word(), 1'b1);
    step(rand_word(), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_run++;
    if (instrD !== NOP || validD !== 1'b0) begin
      n_fail++; $display("FAIL branch_squash got=%h v=%b want NOP v=0", instrD, validD);
    end
    c = rand_word();
    go(c, 1'b1);
    step(rand_word(), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_run++;
    if (instrD !== c || validD !== 1'b1) begin
      n_fail++; $display("FAIL branch_stall_wins got=%h v=%b want=%h v=1", instrD, validD, c);
    end
  endtask

  task automatic test_random();
    restart();
    for (int c = 0; c < 150; c++) begin
      step(rand_word(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
        n_run++;
        if (d_ins[i] !== m_ins[i] || d_v[i] !== m_v[i]) begin
          n_fail++;
          $display("FAIL random_stage%0d c=%0d got=%h/%b want=%h/%b",
                   i, c, d_ins[i], d_v[i], m_ins[i], m_v[i]);
        end
      end
      n_run++;
      if (cycles !== 32'(m_cyc) || retired !== 32'(m_ret) || trace_en !== 1'b1) begin
        n_fail++;
        $display("FAIL random_cnt c=%0d got cyc=%0d ret=%0d ten=%b want %0d/%0d/1",
                 c, cycles, retired, trace_en, m_cyc, m_ret);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    restart();
    for (int i = 0; i < 7; i++) go(rand_word(), 1'b1);
    n_run++;
    if (retired !== 32'd3 || !(validD && validE && validM && validW)) begin
      n_fail++;
      $display("FAIL midrun_setup got ret=%0d v=%b%b%b%b want 3 v=1111",
               retired, validD, validE, validM, validW);
    end
    step(rand_word(), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    n_run++;
    if (instrD !== NOP || instrE !== NOP || instrM !== NOP || instrW !== NOP ||
        validD || validE || validM || validW || cycles !== 32'd0 ||
        retired !== 32'd0 || halted !== 1'b0 || trace_en !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset got D=%h W=%h v=%b%b%b%b cyc=%0d ret=%0d h=%b ten=%b want all zero",
               instrD, instrW, validD, validE, validM, validW, cycles, retired, halted, trace_en);
    end
    go(rand_word(), 1'b1);
    n_run++;
    if (instrD !== NOP || trace_en !== 1'b0) begin
      n_fail++; $display("FAIL midrun_idle got D=%h ten=%b want NOP/0", instrD, trace_en);
    end
  endtask

  task automatic test_saturation();
    restart();
    for (int i = 0; i < 24; i++) go(rand_word(), 1'b1);
    n_run++;
    if (q_cycles !== 4'hf || q_retired !== 4'hf) begin
      n_fail++;
      $display("FAIL sat_cnt4 got cyc=%h ret=%h want f/f", q_cycles, q_retired);
    end
    n_run++;
    if (q_cycles !== 4'(m_cyc4) || q_retired !== 4'(m_ret4) || cycles !== 32'(m_cyc)) begin
      n_fail++;
      $display("FAIL sat_model got cyc4=%0d ret4=%0d cyc=%0d want %0d/%0d/%0d",
               q_cycles, q_retired, cycles, m_cyc4, m_ret4, m_cyc);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; instrF = NOP; validF = 1'b0;
    stallD = 1'b0; flushD = 1'b0; flushE = 1'b0;
    for (int i = 0; i < 4; i++) begin m_ins[i] = NOP; m_v[i] = 1'b0; end
    m_mode = 0; m_cyc = 0; m_ret = 0; m_cyc4 = 0; m_ret4 = 0;
    test_reset();
    test_idle_hold();
    test_straight();
    test_load_use();
    test_branch();
    test_random();
    test_reset_mid_run();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
